// File: rtl/esm_pkg.sv
// Shared types and width helpers for the ESM shuffle buffer.
package esm_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    STEADY = 2'd1,
    DRAIN  = 2'd2
  } esm_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/esm_first_one.sv
// Lowest-set-bit finder over a BS-bit vector.
module esm_first_one
  import esm_pkg::*;
#(
  parameter  int BS = 16,
  localparam int IW = idx_w(BS)
) (
  input  logic [BS-1:0] vec_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = BS - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/esm_shuffle_buffer.sv
// Slot store that evicts at the mapping table's index once full,
// producing a shuffled stream; flush drains all slots.
module esm_shuffle_buffer
  import esm_pkg::*;
#(
  parameter  int BS = 16,
  parameter  int DW = 32,
  localparam int IW = idx_w(BS),
  localparam int CW = cnt_w(BS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          flush_i,
  input  logic [IW-1:0] buffer_index_i,
  output logic [BS-1:0] cand_list_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] out_data_o,
  output logic [CW-1:0] occupancy_o,
  output logic          draining_o
);

  localparam logic [CW-1:0] FULL = CW'(BS);

  esm_state_e    state_q, state_d;
  logic [BS-1:0] cand_q, cand_d;
  logic [CW-1:0] occ_q, occ_d;
  logic          ov_q, ov_d;
  logic [DW-1:0] od_q, od_d;
  logic          drn_q, drn_d;

  logic [DW-1:0] mem [BS];

  logic [IW-1:0] free_idx, low_idx, eff_idx;
  logic          free_found, low_found;
  logic          out_free, accept;
  logic          wr_en, drain_go;
  logic [IW-1:0] wr_idx;

  esm_first_one #(.BS(BS)) u_free (
    .vec_i   (~cand_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  esm_first_one #(.BS(BS)) u_low (
    .vec_i   (cand_q),
    .idx_o   (low_idx),
    .found_o (low_found)
  );

  assign out_free = !ov_q || out_ready_i;
  assign eff_idx  = cand_q[buffer_index_i]
                  ? buffer_index_i : low_idx;

  always_comb begin
    in_ready_o = 1'b0;
    unique case (state_q)
      FILL:    in_ready_o = !flush_i && (occ_q < FULL);
      STEADY:  in_ready_o = !flush_i && out_free;
      default: in_ready_o = 1'b0;
    endcase
  end

  assign accept = in_valid_i && in_ready_o;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    occ_d    = occ_q;
    ov_d     = ov_q && !out_ready_i;
    od_d     = od_q;
    wr_en    = 1'b0;
    wr_idx   = buffer_index_i;
    drain_go = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept && free_found) begin
          wr_en            = 1'b1;
          wr_idx           = free_idx;
          cand_d[free_idx] = 1'b1;
          occ_d            = occ_q + 1'b1;
          if (occ_d == FULL) state_d = STEADY;
        end
        if (flush_i && occ_q != '0) state_d = DRAIN;
      end
      STEADY: begin
        if (accept) begin
          wr_en = 1'b1;
          od_d  = mem[buffer_index_i];
          ov_d  = 1'b1;
        end
        if (flush_i) state_d = DRAIN;
      end
      DRAIN: begin
        drain_go = out_free && occ_q != '0 && low_found;
        if (drain_go) begin
          od_d            = mem[eff_idx];
          ov_d            = 1'b1;
          cand_d[eff_idx] = 1'b0;
          occ_d           = occ_q - 1'b1;
        end
        if (occ_q == '0 && out_free) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
    drn_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      cand_q  <= '0;
      occ_q   <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      drn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      occ_q   <= occ_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      drn_q   <= drn_d;
    end
  end

  // Storage is intentionally unreset; cand_list marks what is live.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= in_data_i;
  end

  assign cand_list_o = cand_q;
  assign occupancy_o = occ_q;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign draining_o  = drn_q;

endmodule
